// File: rtl/ahb3_pkg.sv
// ahb3_pkg: shared encodings and helpers for the AHB3-Lite SRAM slave.
//   - HTRANS / HSIZE / HRESP encodings
//   - data-phase state enum
//   - be_mask(): byte-enable mask from transfer size and lane offset
package ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Mask covering 2^size bytes starting at byte lane 'lane' (max 8 lanes).
    function automatic logic [7:0] be_mask(input logic [2:0] size, input logic [2:0] lane);
        logic [7:0] m;
        case (size)
            HSIZE_BYTE:  m = 8'h01;
            HSIZE_HWORD: m = 8'h03;
            HSIZE_WORD:  m = 8'h0F;
            default:     m = 8'hFF;
        endcase
        return m << lane;
    endfunction

endpackage

// File: rtl/ahb3_sram_bank.sv
// ahb3_sram_bank: DEPTH x DW storage, synchronous byte-lane write,
// asynchronous read. No reset: contents survive HRESET.
//   HCLK  - clock
//   we    - write strobe, be selects the byte lanes written
//   addr  - word index (shared by read and write)
//   wdata - write data, rdata - combinational read of mem[addr]
module ahb3_sram_bank #(
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic                     HCLK,
    input  logic                     we,
    input  logic [DW/8-1:0]          be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);
    localparam int NB = DW / 8;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge HCLK) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb3_sram_slave.sv
// ahb3_sram_slave: AHB3-Lite slave backed by on-chip SRAM, with
// programmable wait states and byte-lane writes.
//   HCLK/HRESET      - clock, synchronous active-high reset
//   HSEL/HADDR/HWRITE/HSIZE/HTRANS/HREADY - address phase
//   HBURST/HPROT     - accepted, unused
//   HWDATA           - write data (data phase)
//   HRDATA/HREADYOUT/HRESP - data-phase response
// Build option: define AHB3_SRAM_ERROR_RESP_EN to answer out-of-range,
// oversize and misaligned transfers with a two-cycle ERROR. Without it
// such transfers wrap / widen / align and HRESP stays OKAY.
module ahb3_sram_slave
    import ahb3_pkg::*;
#(
    parameter int HADDR_SIZE  = 8,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int NB        = HDATA_SIZE / 8;
    localparam int LANE_BITS = $clog2(NB);
    localparam int LW        = (LANE_BITS == 0) ? 1 : LANE_BITS;
    localparam int IW        = $clog2(MEM_DEPTH);

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [HADDR_SIZE-1:0] a_addr;
    logic                  a_write;
    logic [2:0]            a_size;
    logic [HDATA_SIZE-1:0] rd_hold, rd_word;
    logic                  xfer, acc, acc_err, wr_en;
    logic [2:0]            eff_size;
    logic [LW-1:0]         lane;
    logic [IW-1:0]         widx;
    logic [NB-1:0]         be;
    logic                  unused_ok;

    assign unused_ok = ^{HBURST, HPROT};

    always_comb begin
        xfer = 1'b0;
        case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: xfer = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  xfer = 1'b0;
        endcase
    end

    assign acc = HSEL && HREADY && xfer;

`ifdef AHB3_SRAM_ERROR_RESP_EN
    logic [LW-1:0] in_lane;
    assign in_lane = HADDR[LW-1:0] & LW'(NB - 1);
    // Any address bit above the word index means the word is past the array.
    assign acc_err = ((HADDR >> (LANE_BITS + IW)) != '0)
                  || (HSIZE > 3'(LANE_BITS))
                  || ((in_lane & ((LW'(1) << HSIZE) - LW'(1))) != '0);
`else
    assign acc_err = 1'b0;
`endif

    // Data-phase decode. Oversize collapses to full word and the lane is
    // forced to size alignment; with the error path built in, neither case
    // ever reaches ST_DATA so this decode is harmless there.
    always_comb begin
        eff_size = (a_size > 3'(LANE_BITS)) ? 3'(LANE_BITS) : a_size;
        lane     = (a_addr[LW-1:0] & LW'(NB - 1)) & ~((LW'(1) << eff_size) - LW'(1));
        widx     = IW'(a_addr >> LANE_BITS);
        be       = NB'(be_mask(eff_size, 3'(lane)));
    end

    // Only the completing DATA cycle commits; a reset in the same cycle
    // drops the write.
    assign wr_en = (state == ST_DATA) && a_write && !HRESET;

    ahb3_sram_bank #(.DW(HDATA_SIZE), .DEPTH(MEM_DEPTH)) u_bank (
        .HCLK  (HCLK),
        .we    (wr_en),
        .be    (be),
        .addr  (widx),
        .wdata (HWDATA),
        .rdata (rd_word)
    );

    // State register plus address-phase capture. The state itself acts as
    // the address-phase valid flag: anything but an accept returns to IDLE.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rd_hold <= '0;
            a_addr  <= '0;
            a_write <= 1'b0;
            a_size  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (acc) begin
                a_addr  <= HADDR;
                a_write <= HWRITE;
                a_size  <= HSIZE;
            end
            if (state == ST_DATA && !a_write) rd_hold <= rd_word;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = ST_DATA;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                // IDLE, DATA, ERR2 drive HREADYOUT high: a new address
                // phase can be taken on this edge with no bubble.
                if (acc && acc_err) begin
                    state_nxt = ST_ERR1;
                end else if (acc && WAIT_STATES > 0) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = 4'(WAIT_STATES);
                end else if (acc) begin
                    state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRDATA    = rd_hold;
        case (state)
            ST_WAIT, ST_ERR1: HREADYOUT = 1'b0;
            ST_DATA:          if (!a_write) HRDATA = rd_word;
            default: ;
        endcase
`ifdef AHB3_SRAM_ERROR_RESP_EN
        HRESP = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
        HRESP = HRESP_OKAY;
`endif
    end

endmodule

// File: doc/ahb3_sram_slave.md
# ahb3_sram_slave

Parametrised AHB3-Lite slave with on-chip SRAM storage, configurable wait states and byte-lane writes. It generalises the fixed 8-bit-address / 32-bit-data AHB slave interface to arbitrary address width, data width and memory depth. It adds sub-word transfers, programmable wait states and an optional two-cycle ERROR response. It sits behind the AHB decoder as a memory-mapped target and is the next DUT for the AHB verification environment.

## Interface
- HADDR_SIZE, 8: address width in bits
- HDATA_SIZE, 32: data width in bits; 8, 16, 32 or 64
- MEM_DEPTH, 64: storage depth in HDATA_SIZE-wide words; power of two
- WAIT_STATES, 0: HREADYOUT-low cycles per data phase; 0..15

- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  HADDR_SIZE  byte address
- HWDATA  in  HDATA_SIZE  write data, valid in data phase
- HRDATA  out  HDATA_SIZE  read data
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, 2^HSIZE bytes
- HBURST  in  3  burst type; accepted, not used for addressing
- HPROT  in  4  protection; accepted, ignored
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HREADY  in  1  bus-level ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Address phase is accepted when HSEL & HREADY & HTRANS is NONSEQ or SEQ. On acceptance, the block registers HADDR, HWRITE and HSIZE, plus a valid flag.
- IDLE, BUSY, or HSEL=0 with HREADY=1 clears the valid flag. The next data phase completes zero-wait with OKAY.
- States:
  - IDLE: default state.
  - WAIT: entered after a valid accept when WAIT_STATES>0. Counter runs from WAIT_STATES down to 0, then the block goes to DATA.
  - DATA: HREADYOUT=1. The transfer completes here.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1. Returns to IDLE, or straight to the next accepted transfer.
- Word index = registered HADDR >> log2(HDATA_SIZE/8), modulo MEM_DEPTH. Byte lane = HADDR[log2(HDATA_SIZE/8)-1:0]. Byte order is little-endian.
- Write: on the completing DATA cycle, only the 2^HSIZE lanes starting at the lane offset are updated from HWDATA.
- Read: HRDATA carries the full addressed word during the completing cycle. Otherwise HRDATA holds its last value.
- Read after write to the same address in back-to-back transfers returns the newly written data.
- Erroring transfers never modify memory. HRDATA is unchanged during ERR1/ERR2.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, counter 0. Memory contents are unaffected by reset.
- Data-phase length is WAIT_STATES+1 cycles for OKAY transfers and exactly 2 cycles for ERROR transfers.
- Pipelining: the next address phase may be presented during the final data-phase cycle. It is accepted on that same edge, so there are no bubble cycles between transfers.
- HRESET asserted during WAIT or ERR1 abandons the transfer. The pending write is not committed, and the outputs take their reset values on the next edge.
- The master changing HTRANS to IDLE during ERR1 does not shorten ERR2.
- WAIT_STATES=0 means WAIT is never entered.

## Configuration
- AHB3_SRAM_ERROR_RESP_EN defined: the following take the ERR1/ERR2 path:
  - Word index ≥ MEM_DEPTH (no wrap).
  - HSIZE > log2(HDATA_SIZE/8).
  - Address misaligned to HSIZE.
- Not defined: HRESP is tied to 0 and no ERR states are built. Out-of-range addresses wrap modulo MEM_DEPTH. Oversize HSIZE is treated as full-word. Misaligned low address bits are masked to HSIZE alignment.

## Structure
- Package ahb3_pkg holds:
  - HTRANS encodings IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HSIZE encodings BYTE..DWORD.
  - HRESP_OKAY/HRESP_ERROR.
  - State enum.
  - Function computing the byte-enable mask from HSIZE and lane offset.
- Sub-module ahb3_sram_bank: synchronous-write, asynchronous-read array of MEM_DEPTH × HDATA_SIZE with a per-byte write enable. The top contains the FSM, wait counter and address-phase registers.

## Test plan
- Reset with HRESET=1 for 2 cycles: HREADYOUT=1, HRESP=0, HRDATA=0.
- WAIT_STATES=0, 32-bit bus: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back. Read returns 0xDEADBEEF with no HREADYOUT low cycles.
- Byte write 0xAA to 0x11 over that word, then word read of 0x10: returns 0xDEADAAEF.
- WAIT_STATES=3: single read. HREADYOUT is low for exactly 3 cycles, then high with data.
- With AHB3_SRAM_ERROR_RESP_EN and MEM_DEPTH=16: write to 0x40. Response is HREADYOUT 0 then 1 with HRESP=1 both cycles, and a re-read of 0x00 shows it unchanged.
- HRESET asserted in the 2nd wait cycle of a write to 0x20: outputs reset next edge, and a later read of 0x20 returns the old contents.
